// File: rtl/drum_pkg.sv
// drum_pkg: shared state encoding, init timing and sample width for the drum step controller.
package drum_pkg;
    localparam int SMP_W            = 18;
    localparam int INIT_WAIT_CYCLES = 2 * 512 + 4;
    localparam int WAIT_W           = $clog2(INIT_WAIT_CYCLES);

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_INIT_WAIT = 3'd1,
        S_IDLE      = 3'd2,
        S_RUN       = 3'd3,
        S_EMIT      = 3'd4,
        S_WAIT_TICK = 3'd5
    } state_t;
endpackage

// File: rtl/drum_step_controller_if.sv
// drum_step_controller_if: valid/ready sample stream from the controller to the audio sink.
interface drum_step_controller_if;
    import drum_pkg::*;
    logic [SMP_W-1:0] smp_data;
    logic             smp_valid;
    logic             smp_ready;

    modport master (output smp_data, output smp_valid, input smp_ready);
    modport slave  (input smp_data, input smp_valid, output smp_ready);
endinterface

// File: rtl/done_collector.sv
// done_collector: sticky OR of per-column done pulses; all_done includes this cycle's pulses.
module done_collector #(
    parameter int NCOLS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic [NCOLS-1:0] i_pulse,
    output logic             o_all_done
);
    logic [NCOLS-1:0] r_mask;
    logic [NCOLS-1:0] w_mask;

    assign w_mask     = r_mask | i_pulse;
    assign o_all_done = &w_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_mask <= '0;
        else        r_mask <= i_clear ? '0 : w_mask;
    end
endmodule

// File: rtl/drum_step_controller.sv
// drum_step_controller: runs one column-array time step per audio tick, then streams
// the drum-centre amplitude to the sink; also reports step timing and missed ticks.
module drum_step_controller
    import drum_pkg::*;
#(
    parameter int NCOLS = 32,
    parameter int CNTW  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_run_en,
    input  logic                   i_pluck,
    input  logic                   i_sample_tick,
    input  logic [NCOLS-1:0]       i_col_done,
    input  logic [SMP_W-1:0]       i_center_sample,
    output logic                   o_col_reset,
    output logic                   o_start_update,
    drum_step_controller_if.master smp,
    output logic [CNTW-1:0]        o_cycles_per_step,
    output logic [CNTW-1:0]        o_step_count,
    output logic [CNTW-1:0]        o_overrun_count,
    output logic [2:0]             o_state_out
);
    state_t            r_state, w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [CNTW-1:0]   r_cyc, r_cps, r_steps, r_ovr, w_cnt;
    logic [SMP_W-1:0]  r_smp;
    logic              r_pending, r_col_reset;
    logic              w_run, w_emit, w_busy, w_all_done, w_step, w_xfer, w_ovr;

    assign w_run  = r_state == S_RUN;
    assign w_emit = r_state == S_EMIT;
    assign w_busy = w_run || w_emit || r_state == S_WAIT_TICK;
    assign w_cnt  = r_cyc + CNTW'(1);
    assign w_step = w_run && w_all_done && !i_pluck;
    assign w_xfer = smp.smp_valid && smp.smp_ready;
    assign w_ovr  = !i_pluck && w_busy && i_sample_tick && r_pending && !(&r_ovr);

    // done pulses only count while stepping; mask restarts after every step or abort
    done_collector #(.NCOLS(NCOLS)) u_done (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (!w_run || i_pluck || w_all_done),
        .i_pulse    (w_run ? i_col_done : '0),
        .o_all_done (w_all_done)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:      w_next = S_INIT_WAIT;
            S_INIT_WAIT: w_next = (r_wait == WAIT_W'(INIT_WAIT_CYCLES - 1)) ? S_IDLE : S_INIT_WAIT;
            S_IDLE:      w_next = i_run_en ? S_RUN : S_IDLE;
            S_RUN:       w_next = w_all_done ? S_EMIT : S_RUN;
            S_EMIT:      w_next = !w_xfer ? S_EMIT : i_run_en ? S_WAIT_TICK : S_IDLE;
            S_WAIT_TICK: w_next = (i_sample_tick || r_pending) ? S_RUN : S_WAIT_TICK;
            default:     w_next = S_INIT;
        endcase
        if (i_pluck) w_next = S_INIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_INIT;
            r_col_reset <= 1'b0;
            r_wait      <= '0;
            r_cyc       <= '0;
            r_cps       <= '0;
            r_steps     <= '0;
            r_ovr       <= '0;
            r_smp       <= '0;
            r_pending   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_col_reset <= r_state == S_INIT;
            r_wait      <= (r_state == S_INIT_WAIT) ? r_wait + WAIT_W'(1) : '0;
            r_cyc       <= w_run ? w_cnt : '0;
            // a tick during RUN/EMIT is remembered; WAIT_TICK consumes it
            r_pending   <= !i_pluck && ((w_run || w_emit) ? (r_pending || i_sample_tick)
                                                           : (r_state != S_WAIT_TICK && r_pending));
            if (w_step) begin
                r_cps   <= w_cnt;
                r_steps <= r_steps + CNTW'(1);
                r_smp   <= i_center_sample;
            end
            if (w_ovr) r_ovr <= r_ovr + CNTW'(1);
        end
    end

    assign o_col_reset       = r_col_reset;
    assign o_start_update    = w_run;
    assign smp.smp_valid     = w_emit;
    assign smp.smp_data      = r_smp;
    assign o_cycles_per_step = r_cps;
    assign o_step_count      = r_steps;
    assign o_overrun_count   = r_ovr;
    assign o_state_out       = r_state;
endmodule

// File: tb/tb_drum_step_controller.sv
// tb_drum_step_controller: directed scenarios plus random traffic, every cycle compared
// against a behavioural model of the step/emit/tick rules.
module tb_drum_step_controller;
    localparam int NC        = 4;
    localparam int CW        = 32;
    localparam int INIT_WAIT = 1028;

    logic          clk = 1'b0, rst_n = 1'b0, run_en = 1'b0, pluck = 1'b0, tick = 1'b0;
    logic [NC-1:0] done = '0;
    logic [17:0]   center = '0;
    logic          col_reset, start_update;
    logic [CW-1:0] cps, steps, ovr;
    logic [2:0]    st;

    drum_step_controller_if smp();

    drum_step_controller #(.NCOLS(NC), .CNTW(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_run_en          (run_en),
        .i_pluck           (pluck),
        .i_sample_tick     (tick),
        .i_col_done        (done),
        .i_center_sample   (center),
        .o_col_reset       (col_reset),
        .o_start_update    (start_update),
        .smp               (smp),
        .o_cycles_per_step (cps),
        .o_step_count      (steps),
        .o_overrun_count   (ovr),
        .o_state_out       (st)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_checks = 0, n_xfer = 0;

    // model: phase 0..5 as named by the state list, plus what each rule accumulates
    int            m_st, m_wait, m_run;
    bit            m_pend, m_colrst;
    bit            m_seen[NC];
    logic [CW-1:0] m_cps, m_steps, m_ovr;
    logic [17:0]   m_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic m_reset();
        m_st = 0; m_wait = 0; m_run = 0; m_pend = 0; m_colrst = 0;
        m_cps = '0; m_steps = '0; m_ovr = '0; m_data = '0;
        foreach (m_seen[i]) m_seen[i] = 0;
    endtask

    task automatic m_step();
        int prev = m_st;
        bit fin, go;
        m_colrst = (prev == 0);
        if (prev == 3) begin
            m_run++;
            foreach (m_seen[i]) m_seen[i] |= done[i];
        end
        fin = (prev == 3);
        foreach (m_seen[i]) fin &= m_seen[i];
        if (pluck) begin
            m_st = 0; m_pend = 0; m_run = 0;
            foreach (m_seen[i]) m_seen[i] = 0;
            return;
        end
        if (tick && prev >= 3 && m_pend && m_ovr != '1) m_ovr++;
        go = tick || m_pend;
        if (prev == 5) m_pend = 0;
        else if (tick && (prev == 3 || prev == 4)) m_pend = 1;
        case (prev)
            0: begin m_st = 1; m_wait = 0; end
            1: begin m_wait++; if (m_wait == INIT_WAIT) m_st = 2; end
            2: if (run_en) m_st = 3;
            3: if (fin) begin
                   m_cps = CW'(m_run); m_steps++; m_data = center; m_run = 0;
                   foreach (m_seen[i]) m_seen[i] = 0;
                   m_st = 4;
               end
            4: if (smp.smp_ready) m_st = run_en ? 5 : 2;
            5: if (go) m_st = 3;
            default: m_st = 0;
        endcase
    endtask

    task automatic compare();
        chk("state", st, m_st);
        chk("col_reset", col_reset, m_colrst);
        chk("start_update", start_update, m_st == 3);
        chk("smp_valid", smp.smp_valid, m_st == 4);
        chk("smp_data", smp.smp_data, m_data);
        chk("cycles_per_step", cps, m_cps);
        chk("step_count", steps, m_steps);
        chk("overrun_count", ovr, m_ovr);
    endtask

    task automatic cyc();
        if (smp.smp_valid && smp.smp_ready) n_xfer++;
        @(posedge clk);
        m_step();
        @(negedge clk);
        compare();
    endtask

    task automatic reach_emit();
        int n = 0;
        pluck = 0; run_en = 1; smp.smp_ready = 0; done = '1; tick = 1;
        while (st != 3'd4 && n < 2000) begin cyc(); n++; end
        done = '0; tick = 0;
        chk("reach_emit", st, 4);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int x0;
        smp.smp_ready = 0;
        m_reset();
        repeat (2) begin @(negedge clk); compare(); end
        chk("rst_start_update", start_update, 0);
        chk("rst_col_reset", col_reset, 0);
        rst_n = 1;

        // reset release: col_reset on cycle 1, then the init wait
        for (int k = 1; k <= 1030; k++) begin
            cyc();
            if (k == 1) chk("col_reset_cycle1", col_reset, 1);
            if (k == 2) chk("col_reset_cycle2", col_reset, 0);
            if (k == 1028) chk("init_wait_1028", st, 1);
            if (k == 1030) begin chk("idle_1030", st, 2); chk("idle_no_update", start_update, 0); end
        end

        // one step: done bits at cycles 3,5,5,9 after RUN entry
        run_en = 1;
        cyc();
        chk("run_entry", st, 3);
        for (int c = 0; c <= 9; c++) begin
            done = '0;
            if (c == 3) done[0] = 1;
            if (c == 5) done[2:1] = 2'b11;
            if (c == 9) done[3] = 1;
            center = (c == 9) ? 18'h1F000 : 18'($urandom);
            cyc();
        end
        done = '0;
        chk("step1_cps", cps, 10);
        chk("step1_count", steps, 1);
        chk("step1_emit", st, 4);

        // sink stalls for 5 cycles
        x0 = n_xfer;
        for (int c = 0; c < 5; c++) begin
            center = 18'($urandom);
            cyc();
            chk("emit_hold_data", smp.smp_data, 18'h1F000);
            chk("emit_hold_valid", smp.smp_valid, 1);
        end
        smp.smp_ready = 1;
        cyc();
        smp.smp_ready = 0;
        chk("after_xfer_wait", st, 5);
        repeat (2) cyc();
        chk("single_transfer", n_xfer - x0, 1);
        chk("wait_holds", st, 5);

        // three ticks in one long RUN
        tick = 1; cyc(); tick = 0;
        chk("tick_to_run", st, 3);
        for (int c = 0; c <= 15; c++) begin
            tick = (c == 2 || c == 6 || c == 10);
            done = (c == 15) ? '1 : '0;
            cyc();
        end
        tick = 0; done = '0;
        chk("ovr_two", ovr, 2);
        chk("step2_cps", cps, 16);
        chk("step2_count", steps, 2);
        smp.smp_ready = 1; cyc(); smp.smp_ready = 0;
        chk("pending_wait", st, 5);
        cyc();
        chk("wait_immediate_exit", st, 3);

        // pluck mid-RUN
        done = 4'b0011; cyc(); done = '0; cyc();
        pluck = 1; cyc(); pluck = 0;
        chk("pluck_no_update", start_update, 0);
        chk("pluck_init", st, 0);
        chk("pluck_steps_kept", steps, 2);
        cyc();
        chk("pluck_col_reset", col_reset, 1);
        cyc();
        chk("pluck_col_reset_off", col_reset, 0);

        // random traffic
        for (int k = 0; k < 4000; k++) begin
            run_en        = $urandom_range(0, 15) != 0;
            pluck         = $urandom_range(0, 1499) == 0;
            tick          = $urandom_range(0, 24) == 0;
            smp.smp_ready = $urandom_range(0, 2) != 0;
            center        = 18'($urandom);
            for (int i = 0; i < NC; i++) done[i] = $urandom_range(0, 5) == 0;
            cyc();
        end

        // pluck together with a transfer
        reach_emit();
        x0 = n_xfer;
        smp.smp_ready = 1; pluck = 1; cyc(); pluck = 0; smp.smp_ready = 0;
        chk("pluck_xfer_count", n_xfer - x0, 1);
        chk("pluck_xfer_init", st, 0);

        // asynchronous reset in the middle of EMIT
        reach_emit();
        #2 rst_n = 0;
        #1;
        chk("async_valid_drop", smp.smp_valid, 0);
        chk("async_state", st, 0);
        chk("async_steps", steps, 0);
        chk("async_cps", cps, 0);
        chk("async_ovr", ovr, 0);
        chk("async_data", smp.smp_data, 0);
        m_reset();
        @(negedge clk); compare();
        rst_n = 1; run_en = 0;
        cyc();
        chk("rerst_col_reset", col_reset, 1);
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
